gshare_predictor: RTL and testbench

Parametrised gshare conditional-branch predictor with per-entry 2-bit saturating counters and a speculative global history register (GHR) with checkpoint/restore. Sits beside the fetch stage: predicts combinationally from the fetch PC and current GHR, and is trained and repaired from the execute stage when a branch resolves. Also keeps saturating branch and mispredict counters for performance monitoring.

---
 rtl/gshare_predictor.sv | 103 ++++++++++
 tb/tb_gshare_predictor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// gshare conditional-branch predictor: a table of 2-bit saturating counters
// indexed by PC XOR global history, a speculative GHR that is repaired from a
// checkpoint on mispredict, and saturating branch/mispredict counters.
module gshare_predictor #(
  parameter int         N_BITS   = 8,
  parameter int         HIST_LEN = 8,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         fetch_pc,
  input  logic                fetch_valid,
  output logic                predict_taken,
  output logic [HIST_LEN-1:0] predict_ghr,
  input  logic                update_valid,
  input  logic [31:0]         update_pc,
  input  logic [HIST_LEN-1:0] update_ghr,
  input  logic                update_taken,
  input  logic                update_mispredict,
  output logic [31:0]         branch_count,
  output logic [31:0]         mispredict_count
);

  localparam int ENTRIES = 1 << N_BITS;

  logic [ENTRIES-1:0][1:0] r_pht;
  logic [HIST_LEN-1:0]     r_ghr;
  logic [31:0]             r_branch_count;
  logic [31:0]             r_mispredict_count;

  logic [N_BITS-1:0]       w_fetch_idx;
  logic [N_BITS-1:0]       w_upd_idx;
  logic                    w_repair;
  logic [HIST_LEN-1:0]     w_repair_ghr;
  logic [HIST_LEN-1:0]     w_spec_ghr;
  logic                    w_unused;

  // Step a 2-bit counter one position toward the resolved direction.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11)
      nxt = ctr + 2'b01;
    else if (!taken && ctr != 2'b00)
      nxt = ctr - 2'b01;
    return nxt;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // History is zero-extended and XORed into the low index bits.
  assign w_fetch_idx   = fetch_pc[N_BITS+1:2] ^ N_BITS'(r_ghr);
  assign w_upd_idx     = update_pc[N_BITS+1:2] ^ N_BITS'(update_ghr);

  // Truncating the concatenation shifts in the new bit and also covers HIST_LEN == 1.
  assign w_repair      = update_valid & update_mispredict;
  assign w_repair_ghr  = HIST_LEN'({update_ghr, update_taken});
  assign w_spec_ghr    = HIST_LEN'({r_ghr, predict_taken});

  assign predict_taken    = r_pht[w_fetch_idx][1];
  assign predict_ghr      = r_ghr;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

  // PC bits outside the index window are intentionally ignored.
  assign w_unused = ^{fetch_pc[31:N_BITS+2], fetch_pc[1:0],
                      update_pc[31:N_BITS+2], update_pc[1:0]};

  // Train the resolved entry; a same-cycle fetch of that entry sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pht <= {ENTRIES{CTR_INIT}};
    else if (update_valid)
      r_pht[w_upd_idx] <= ctr_step(r_pht[w_upd_idx], update_taken);
  end

  // Mispredict repair outranks the speculative shift, which is wrong-path then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ghr <= '0;
    else if (w_repair)
      r_ghr <= w_repair_ghr;
    else if (fetch_valid)
      r_ghr <= w_spec_ghr;
  end

  // Saturating performance counters for resolved branches and mispredicts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (update_valid)
        r_branch_count <= sat_inc(r_branch_count);
      if (w_repair)
        r_mispredict_count <= sat_inc(r_mispredict_count);
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: directed scenarios plus random traffic, all
// compared against an array-based reference model of the predictor.
module tb_gshare_predictor;

  localparam int N_BITS   = 8;
  localparam int HIST_LEN = 8;
  localparam int ENTRIES  = 1 << N_BITS;
  localparam int HMASK    = (1 << HIST_LEN) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [31:0]         fetch_pc = '0;
  logic                fetch_valid = 1'b0;
  logic                predict_taken;
  logic [HIST_LEN-1:0] predict_ghr;
  logic                update_valid = 1'b0;
  logic [31:0]         update_pc = '0;
  logic [HIST_LEN-1:0] update_ghr = '0;
  logic                update_taken = 1'b0;
  logic                update_mispredict = 1'b0;
  logic [31:0]         branch_count;
  logic [31:0]         mispredict_count;

  gshare_predictor #(.N_BITS(N_BITS), .HIST_LEN(HIST_LEN), .CTR_INIT(2'b01)) dut (
    .clk(clk), .rst(rst),
    .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
    .predict_taken(predict_taken), .predict_ghr(predict_ghr),
    .update_valid(update_valid), .update_pc(update_pc), .update_ghr(update_ghr),
    .update_taken(update_taken), .update_mispredict(update_mispredict),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: counter values 0..3, history as an integer.
  int     m_ctr [ENTRIES];
  int     m_ghr;
  longint m_bc, m_mc;
  logic   last_pt;
  logic [HIST_LEN-1:0] last_pghr;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc, input int g);
    return ((pc >> 2) % ENTRIES) ^ g;
  endfunction

  function automatic longint sat32(input longint v);
    return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
  endfunction

  task automatic model_reset();
    foreach (m_ctr[i]) m_ctr[i] = 1;
    m_ghr = 0;
    m_bc  = 0;
    m_mc  = 0;
  endtask

  // One clock cycle: drive at negedge, compare combinational outputs, advance model and DUT.
  task automatic step(input bit fv, input logic [31:0] fpc, input bit uv, input logic [31:0] upc,
                      input int ug, input bit ut, input bit um);
    bit exp_pt;
    int ui;
    @(negedge clk);
    fetch_valid = fv; fetch_pc = fpc;
    update_valid = uv; update_pc = upc; update_ghr = ug[HIST_LEN-1:0];
    update_taken = ut; update_mispredict = um;
    #1;
    exp_pt = (m_ctr[m_idx(fpc, m_ghr)] >= 2);
    chk("predict_taken", predict_taken, exp_pt);
    chk("predict_ghr", predict_ghr, m_ghr);
    chk("branch_count", branch_count, m_bc);
    chk("mispredict_count", mispredict_count, m_mc);
    last_pt   = predict_taken;
    last_pghr = predict_ghr;
    if (uv) begin
      ui = m_idx(upc, ug & HMASK);
      if (ut) m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
      else    m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
      m_bc = sat32(m_bc);
      if (um) m_mc = sat32(m_mc);
    end
    if (uv && um)  m_ghr = ((ug * 2) + int'(ut)) & HMASK;
    else if (fv)   m_ghr = ((m_ghr * 2) + int'(exp_pt)) & HMASK;
    @(posedge clk);
    #1;
    fetch_valid = 1'b0; update_valid = 1'b0; update_mispredict = 1'b0;
  endtask

  // Combinational look at the prediction for a PC with no valids asserted.
  task automatic peek(input string tag, input logic [31:0] pc, input bit exp);
    fetch_valid = 1'b0; update_valid = 1'b0; fetch_pc = pc;
    #1;
    chk(tag, predict_taken, exp);
  endtask

  // Asynchronous reset mid-cycle, with updates held high that must be dropped.
  task automatic reset_dut(input bit sweep);
    @(negedge clk);
    #2;
    rst = 1'b1;
    fetch_valid = 1'b1; update_valid = 1'b1; update_mispredict = 1'b1;
    update_taken = 1'b1; update_pc = 32'h0000_0100; fetch_pc = 32'h0000_0100;
    #1;
    model_reset();
    chk("rst_predict_taken", predict_taken, 1'b0);
    chk("rst_predict_ghr", predict_ghr, 0);
    chk("rst_branch_count", branch_count, 0);
    chk("rst_mispredict_count", mispredict_count, 0);
    @(posedge clk);
    #1;
    chk("rst_drop_branch_count", branch_count, 0);
    chk("rst_drop_mispredict_count", mispredict_count, 0);
    if (sweep) begin
      fetch_valid = 1'b0; update_valid = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        fetch_pc = 32'(i) << 2;
        #1;
        chk("rst_entry", predict_taken, 1'b0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    fetch_valid = 1'b0; update_valid = 1'b0; update_mispredict = 1'b0;
  endtask

  bit sat_exp [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    model_reset();
    reset_dut(1'b1);

    // Counter saturation on entry for 0x100 with GHR = 0.
    peek("sat_t0", 32'h100, 1'b0);
    step(0, 32'h0, 1, 32'h100, 0, 1, 0);
    peek("sat_t1", 32'h100, 1'b1);
    step(0, 32'h0, 1, 32'h100, 0, 1, 0);
    peek("sat_t2", 32'h100, 1'b1);
    step(0, 32'h0, 1, 32'h100, 0, 1, 0);
    peek("sat_t3", 32'h100, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(0, 32'h0, 1, 32'h100, 0, 0, 0);
      peek("sat_nt", 32'h100, sat_exp[k]);
    end

    // Speculative history: predictions 0,1,1 from GHR = 0.
    step(0, 32'h0, 1, 32'h300, 0, 1, 0);
    step(0, 32'h0, 1, 32'h300, 0, 1, 0);
    step(0, 32'h0, 1, 32'h304, 0, 1, 0);
    step(0, 32'h0, 1, 32'h304, 0, 1, 0);
    step(1, 32'h200, 0, 32'h0, 0, 0, 0);
    chk("spec_pred0", last_pt, 1'b0);
    step(1, 32'h300, 0, 32'h0, 0, 0, 0);
    chk("spec_pred1", last_pt, 1'b1);
    step(1, 32'h300, 0, 32'h0, 0, 0, 0);
    chk("spec_pred2", last_pt, 1'b1);
    chk("spec_pghr2", last_pghr, 8'h01);
    #1;
    chk("spec_ghr_final", predict_ghr, 8'h03);

    // Mispredict repair wins over a same-cycle fetch.
    reset_dut(1'b0);
    @(negedge clk);
    force dut.r_ghr = 8'hA5;
    #1;
    release dut.r_ghr;
    m_ghr = 8'hA5;
    step(1, 32'h40, 1, 32'h2000, 8'h3C, 1, 1);
    chk("repair_ghr", predict_ghr, 8'h79);
    chk("repair_mcount", mispredict_count, 1);

    // Aliasing: 0x404 with GHR=1 and 0x400 with GHR=0 share an entry.
    reset_dut(1'b0);
    step(0, 32'h0, 1, 32'h804, 0, 1, 1);
    chk("alias_ghr", predict_ghr, 8'h01);
    peek("alias_before", 32'h404, 1'b0);
    step(0, 32'h0, 1, 32'h400, 0, 1, 0);
    peek("alias_after", 32'h404, 1'b1);

    // Branch counter saturation.
    @(negedge clk);
    force dut.r_branch_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_branch_count;
    m_bc = 64'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) step(0, 32'h0, 1, 32'h10, 0, 0, 0);
    #1;
    chk("bcount_sat", branch_count, 32'hFFFF_FFFF);

    // Random traffic against the model.
    reset_dut(1'b0);
    for (int n = 0; n < 2000; n++) begin
      step(bit'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)) << 2,
           bit'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)) << 2,
           int'($urandom_range(0, HMASK)), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0));
    end

    // Mid-stream reset after random training restores every entry.
    reset_dut(1'b1);
    step(1, 32'h0, 0, 32'h0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
